ctrl_pipe: RTL and testbench

Parametrised decode-and-control pipeline for the RV32I core. Decodes opcode/funct3/funct7 in D and registers the control bundle into E. It carries the memory and writeback controls through a configurable number of M stages into W. It also provides per-stage stall/flush and an ECALL halt state machine that drains the pipeline before asserting `stop`. It sits between the instruction register and the datapath/hazard unit.

---
 rtl/ctrl_pipe.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I decode-and-control pipeline D -> E -> M1..Mk -> W.
// D decodes opcode/funct3/funct7 into a control bundle that is registered
// into E, then memory/writeback controls travel through M_STAGES memory
// stages into W. Per-stage stall/flush and an ECALL drain-then-halt FSM.
// Optional feature macro: CTRL_MULDIV_EN (RV32M decode of funct7=0000001).
module ctrl_pipe #(
  parameter int M_STAGES = 1,
  parameter int ALUOP_W  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               valid_d,
  input  logic               stall,
  input  logic               flush,
  input  logic               eflush,
  input  logic               resume,
  output logic [2:0]         mode,
  output logic [2:0]         branch_e,
  output logic [ALUOP_W-1:0] alu_op_e,
  output logic               alu_src1_e,
  output logic [1:0]         alu_src2_e,
  output logic               uors_e,
  output logic               sp_sign_e,
  output logic               mem_read_e,
  output logic [2:0]         extmode2_e,
  output logic               muldiv_e,
  output logic               mem_write_m,
  output logic               mem_to_reg_m,
  output logic               reg_write_m,
  output logic [2:0]         extmode1_m,
  output logic               reg_write_w,
  output logic               stop
);

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Drain length covers E plus every M stage so W sees the last real op.
  localparam logic [2:0] CNT_INIT = 3'(M_STAGES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  // Controls that continue past E into the memory/writeback stages.
  typedef struct packed {
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] extmode1;
  } mctl_t;

  typedef struct packed {
    logic [2:0]         branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src1;
    logic [1:0]         alu_src2;
    logic               uors;
    logic               sp_sign;
    logic               mem_read;
    logic [2:0]         extmode2;
    logic               muldiv;
    mctl_t              mctl;
  } ectl_t;

  state_t state_q, state_nx;
  logic [2:0] cnt_q, cnt_nx;

  ectl_t dec_d;
  logic  ecall_d;
  logic  vld_d;
  logic  e_load;

  ectl_t                ctl_p0;
  logic                 vld_p0;
  mctl_t                ctl_pm [M_STAGES];
  logic [M_STAGES-1:0]  vld_pm;
  logic                 reg_write_pw;
  logic                 vld_pw;

`ifndef CTRL_MULDIV_EN
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

  // E accepts the D decode only when nothing kills or holds it this cycle.
  assign e_load = !flush && !eflush && !stall;

  // Immediate-format code straight from the D-stage opcode.
  always_comb begin
    mode = 3'd0;
    case (opcode)
      OP_ALUI:           mode = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd2 : 3'd1;
      OP_LOAD:           mode = 3'd1;
      OP_LUI, OP_AUIPC:  mode = 3'd3;
      OP_BRANCH:         mode = 3'd5;
      OP_STORE:          mode = 3'd6;
      default:           mode = 3'd0;
    endcase
  end

  // D-stage decode; anything outside RUN or without valid_d is a bubble.
  always_comb begin
    dec_d   = '0;
    ecall_d = 1'b0;
    vld_d   = 1'b0;
    if (valid_d && state_q == S_RUN) begin
      case (opcode)
        OP_ALUI: begin
          vld_d                = 1'b1;
          dec_d.alu_op         = ALUOP_W'(funct3);
          dec_d.alu_src1       = 1'b1;
          dec_d.mctl.reg_write = 1'b1;
        end
        OP_ALU: begin
          vld_d                = 1'b1;
          dec_d.mctl.reg_write = 1'b1;
`ifdef CTRL_MULDIV_EN
          if (funct7 == 7'b0000001) begin
            dec_d.alu_op = ALUOP_W'({1'b1, funct3});
            dec_d.muldiv = 1'b1;
          end else begin
            dec_d.alu_op = ALUOP_W'({1'b0, funct3});
          end
`else
          dec_d.alu_op = ALUOP_W'({1'b0, funct3});
`endif
        end
        OP_LUI: begin
          vld_d                = 1'b1;
          dec_d.alu_src1       = 1'b1;
          dec_d.alu_src2       = 2'd2;
          dec_d.mctl.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          vld_d                = 1'b1;
          dec_d.alu_src1       = 1'b1;
          dec_d.alu_src2       = 2'd1;
          dec_d.mctl.reg_write = 1'b1;
        end
        OP_BRANCH: begin
          vld_d = 1'b1;
          case (funct3)
            3'b000: begin dec_d.alu_op = ALUOP_W'(3'b010); dec_d.branch = 3'b010; end
            3'b001: begin dec_d.alu_op = ALUOP_W'(3'b010); dec_d.branch = 3'b101; end
            3'b100: begin dec_d.alu_op = ALUOP_W'(3'b010); dec_d.branch = 3'b100; end
            3'b101: begin dec_d.alu_op = ALUOP_W'(3'b010); dec_d.branch = 3'b011; end
            3'b110: begin dec_d.alu_op = ALUOP_W'(3'b011); dec_d.branch = 3'b100; dec_d.uors = 1'b1; end
            3'b111: begin dec_d.alu_op = ALUOP_W'(3'b011); dec_d.branch = 3'b011; dec_d.uors = 1'b1; end
            default: ;
          endcase
        end
        OP_LOAD: begin
          vld_d                 = 1'b1;
          dec_d.mem_read        = 1'b1;
          dec_d.alu_src1        = 1'b1;
          dec_d.mctl.mem_to_reg = 1'b1;
          dec_d.mctl.reg_write  = 1'b1;
          case (funct3)
            3'b000:  dec_d.mctl.extmode1 = 3'b001;
            3'b001:  dec_d.mctl.extmode1 = 3'b011;
            3'b100:  dec_d.mctl.extmode1 = 3'b010;
            3'b101:  dec_d.mctl.extmode1 = 3'b100;
            default: dec_d.mctl.extmode1 = 3'b000;
          endcase
        end
        OP_STORE: begin
          vld_d                = 1'b1;
          dec_d.alu_src1       = 1'b1;
          dec_d.mctl.mem_write = 1'b1;
          case (funct3)
            3'b000:  dec_d.extmode2 = 3'b010;
            3'b001:  dec_d.extmode2 = 3'b100;
            default: dec_d.extmode2 = 3'b000;
          endcase
        end
        OP_SYSTEM: begin
          vld_d   = 1'b1;
          ecall_d = 1'b1;
        end
        default: ;
      endcase
      if (vld_d && !ecall_d) dec_d.sp_sign = funct7[5];
    end
  end

  // Halt FSM state and drain counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Halt FSM: enter DRAIN when an ECALL lands in E, halt once drained.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    stop     = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ecall_d && e_load) begin
          state_nx = S_DRAIN;
          cnt_nx   = CNT_INIT;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 3'd0) state_nx = S_HALT;
        else               cnt_nx   = cnt_q - 3'd1;
      end
      S_HALT: begin
        stop = 1'b1;
        if (resume) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // D -> E boundary: flushes load a bubble, stall holds E.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctl_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (flush || eflush) begin
      ctl_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      ctl_p0 <= dec_d;
      vld_p0 <= vld_d;
    end
  end

  // E -> M1 -> ... -> Mk boundary: M1 bubbles on flush or a plain stall, later stages always shift.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < M_STAGES; i++) ctl_pm[i] <= '0;
      vld_pm <= '0;
    end else begin
      if (flush || (stall && !eflush)) begin
        ctl_pm[0] <= '0;
        vld_pm[0] <= 1'b0;
      end else begin
        ctl_pm[0] <= ctl_p0.mctl;
        vld_pm[0] <= vld_p0;
      end
      for (int i = 1; i < M_STAGES; i++) begin
        ctl_pm[i] <= ctl_pm[i-1];
        vld_pm[i] <= vld_pm[i-1];
      end
    end
  end

  // Mk -> W boundary: always advances.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      reg_write_pw <= 1'b0;
      vld_pw       <= 1'b0;
    end else begin
      reg_write_pw <= ctl_pm[M_STAGES-1].reg_write;
      vld_pw       <= vld_pm[M_STAGES-1];
    end
  end

  assign branch_e     = ctl_p0.branch;
  assign alu_op_e     = ctl_p0.alu_op;
  assign alu_src1_e   = ctl_p0.alu_src1;
  assign alu_src2_e   = ctl_p0.alu_src2;
  assign uors_e       = ctl_p0.uors;
  assign sp_sign_e    = ctl_p0.sp_sign;
  assign mem_read_e   = ctl_p0.mem_read;
  assign extmode2_e   = ctl_p0.extmode2;
  assign muldiv_e     = ctl_p0.muldiv;
  assign mem_write_m  = ctl_pm[0].mem_write & vld_pm[0];
  assign mem_to_reg_m = ctl_pm[M_STAGES-1].mem_to_reg & vld_pm[M_STAGES-1];
  assign reg_write_m  = ctl_pm[M_STAGES-1].reg_write & vld_pm[M_STAGES-1];
  assign extmode1_m   = ctl_pm[M_STAGES-1].extmode1 & {3{vld_pm[M_STAGES-1]}};
  assign reg_write_w  = reg_write_pw & vld_pw;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios plus randomized traffic,
// compared against a behavioural model of the decode table, stage chain
// and ECALL halt timing.
module tb_ctrl_pipe;
  localparam int M  = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic valid_d = 1'b0, stall = 1'b0, flush = 1'b0, eflush = 1'b0, resume = 1'b0;
  logic [2:0] mode, branch_e, extmode2_e, extmode1_m;
  logic [AW-1:0] alu_op_e;
  logic alu_src1_e, uors_e, sp_sign_e, mem_read_e, muldiv_e;
  logic [1:0] alu_src2_e;
  logic mem_write_m, mem_to_reg_m, reg_write_m, reg_write_w, stop;

  int n_cmp = 0;
  int n_fail = 0;

  ctrl_pipe #(.M_STAGES(M), .ALUOP_W(AW)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .valid_d(valid_d), .stall(stall), .flush(flush), .eflush(eflush), .resume(resume),
    .mode(mode), .branch_e(branch_e), .alu_op_e(alu_op_e), .alu_src1_e(alu_src1_e),
    .alu_src2_e(alu_src2_e), .uors_e(uors_e), .sp_sign_e(sp_sign_e), .mem_read_e(mem_read_e),
    .extmode2_e(extmode2_e), .muldiv_e(muldiv_e), .mem_write_m(mem_write_m),
    .mem_to_reg_m(mem_to_reg_m), .reg_write_m(reg_write_m), .extmode1_m(extmode1_m),
    .reg_write_w(reg_write_w), .stop(stop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] branch; logic [AW-1:0] alu_op; logic src1; logic [1:0] src2;
    logic uors; logic sp; logic mem_read; logic [2:0] ext2; logic muldiv;
    logic mem_write; logic mem_to_reg; logic reg_write; logic [2:0] ext1; logic ecall;
  } ctl_t;

  // Reference state: E contents, M1..Mk contents, W reg_write, halt timing.
  ctl_t me;
  ctl_t mm [M];
  logic mw = 1'b0;
  int   ecall_age = -1;
  logic halted = 1'b0;

  wire [20+AW:0] dut_all = {branch_e, alu_op_e, alu_src1_e, alu_src2_e, uors_e, sp_sign_e,
                            mem_read_e, extmode2_e, muldiv_e, mem_write_m, mem_to_reg_m,
                            reg_write_m, extmode1_m, reg_write_w, stop};

  function automatic logic [20+AW:0] model_all();
    return {me.branch, me.alu_op, me.src1, me.src2, me.uors, me.sp, me.mem_read, me.ext2,
            me.muldiv, mm[0].mem_write, mm[M-1].mem_to_reg, mm[M-1].reg_write, mm[M-1].ext1,
            mw, halted};
  endfunction

  function automatic logic [2:0] model_mode(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0010011: return (f3 == 3'b001 || f3 == 3'b101) ? 3'd2 : 3'd1;
      7'b0000011: return 3'd1;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1100011: return 3'd5;
      7'b0100011: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic ctl_t model_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic v);
    ctl_t c;
    c = '0;
    if (v) begin
      case (op)
        7'b0010011: begin c.alu_op = AW'(f3); c.src1 = 1; c.reg_write = 1; c.sp = f7[5]; end
        7'b0110011: begin
          c.alu_op = AW'(f3); c.reg_write = 1; c.sp = f7[5];
`ifdef CTRL_MULDIV_EN
          if (f7 == 7'b0000001) begin c.alu_op = AW'(8 + int'(f3)); c.muldiv = 1; end
`endif
        end
        7'b0110111: begin c.src1 = 1; c.src2 = 2; c.reg_write = 1; c.sp = f7[5]; end
        7'b0010111: begin c.src1 = 1; c.src2 = 1; c.reg_write = 1; c.sp = f7[5]; end
        7'b1100011: begin
          c.sp = f7[5];
          case (f3)
            3'd0: begin c.alu_op = AW'(2); c.branch = 3'b010; end
            3'd1: begin c.alu_op = AW'(2); c.branch = 3'b101; end
            3'd4: begin c.alu_op = AW'(2); c.branch = 3'b100; end
            3'd5: begin c.alu_op = AW'(2); c.branch = 3'b011; end
            3'd6: begin c.alu_op = AW'(3); c.branch = 3'b100; c.uors = 1; end
            3'd7: begin c.alu_op = AW'(3); c.branch = 3'b011; c.uors = 1; end
            default: ;
          endcase
        end
        7'b0000011: begin
          c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.src1 = 1; c.sp = f7[5];
          case (f3)
            3'd0: c.ext1 = 3'b001;
            3'd1: c.ext1 = 3'b011;
            3'd4: c.ext1 = 3'b010;
            3'd5: c.ext1 = 3'b100;
            default: c.ext1 = 3'b000;
          endcase
        end
        7'b0100011: begin
          c.mem_write = 1; c.src1 = 1; c.sp = f7[5];
          c.ext2 = (f3 == 3'd0) ? 3'b010 : (f3 == 3'd1) ? 3'b100 : 3'b000;
        end
        7'b1110011: c.ecall = 1;
        default: ;
      endcase
    end
    return c;
  endfunction

  // Advance the reference by one clock using the inputs sampled at the edge.
  task automatic model_step();
    ctl_t dec;
    logic blocked;
    if (!rstn) begin
      me = '0;
      for (int i = 0; i < M; i++) mm[i] = '0;
      mw = 1'b0; ecall_age = -1; halted = 1'b0;
    end else begin
      blocked = (ecall_age >= 0) || halted;
      if (blocked) dec = '0;
      else dec = model_decode(opcode, funct3, funct7, valid_d);
      mw = mm[M-1].reg_write;
      for (int i = M - 1; i > 0; i--) mm[i] = mm[i-1];
      if (flush) mm[0] = '0;
      else if (eflush) mm[0] = me;
      else if (stall) mm[0] = '0;
      else mm[0] = me;
      if (flush || eflush) me = '0;
      else if (!stall) me = dec;
      if (halted) begin
        if (resume) halted = 1'b0;
      end else if (ecall_age >= 0) begin
        ecall_age++;
        if (ecall_age == M + 2) begin halted = 1'b1; ecall_age = -1; end
      end else if (dec.ecall && !flush && !eflush && !stall) begin
        ecall_age = 0;
      end
    end
  endtask

  task automatic setin(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v, input logic st, input logic fl, input logic ef,
                       input logic rs);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7; valid_d = v;
    stall = st; flush = fl; eflush = ef; resume = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    setin(7'b1110011, 3'b101, 7'h7f, 1, 1, 0, 0, 1);
    rstn = 1'b0;
    #1;
    n_cmp++; if (mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode); end
    tick(); tick();
    n_cmp++; if (dut_all !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", dut_all); end
    rstn = 1'b1;
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (dut_all !== model_all()) begin n_fail++; $display("FAIL reset_exit: got %h want %h", dut_all, model_all()); end
  endtask

  task automatic test_addi();
    do_reset();
    setin(7'b0010011, 3'b000, 7'd0, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (mode !== 3'd1) begin n_fail++; $display("FAIL addi_mode: got %0d want 1", mode); end
    tick();
    n_cmp++; if (alu_src1_e !== 1'b1 || alu_op_e !== AW'(0)) begin n_fail++; $display("FAIL addi_e: src1=%0b op=%b want 1/0000", alu_src1_e, alu_op_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    for (int k = 0; k < M; k++) tick();
    n_cmp++; if (reg_write_m !== 1'b1) begin n_fail++; $display("FAIL addi_mk: reg_write_m=%0b want 1", reg_write_m); end
    tick();
    n_cmp++; if (reg_write_w !== 1'b1) begin n_fail++; $display("FAIL addi_w: reg_write_w=%0b want 1", reg_write_w); end
  endtask

  task automatic test_bltu();
    do_reset();
    setin(7'b1100011, 3'b110, 7'd0, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (mode !== 3'd5) begin n_fail++; $display("FAIL bltu_mode: got %0d want 5", mode); end
    tick();
    n_cmp++; if (alu_op_e !== AW'(3) || branch_e !== 3'b100 || uors_e !== 1'b1) begin n_fail++; $display("FAIL bltu_e: op=%b br=%b uors=%0b want 0011/100/1", alu_op_e, branch_e, uors_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    for (int k = 0; k < M + 2; k++) begin
      tick();
      n_cmp++; if (reg_write_m !== 1'b0 || reg_write_w !== 1'b0) begin n_fail++; $display("FAIL bltu_rw: m=%0b w=%0b want 0/0", reg_write_m, reg_write_w); end
    end
  endtask

  task automatic test_load();
    do_reset();
    setin(7'b0000011, 3'b001, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (mem_read_e !== 1'b1 || alu_src1_e !== 1'b1) begin n_fail++; $display("FAIL lh_e: mem_read=%0b src1=%0b want 1/1", mem_read_e, alu_src1_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    for (int k = 0; k < M; k++) tick();
    n_cmp++; if (extmode1_m !== 3'b011 || mem_to_reg_m !== 1'b1) begin n_fail++; $display("FAIL lh_mk: ext1=%b m2r=%0b want 011/1", extmode1_m, mem_to_reg_m); end
    tick();
    n_cmp++; if (reg_write_w !== 1'b1) begin n_fail++; $display("FAIL lh_w: reg_write_w=%0b want 1", reg_write_w); end
  endtask

  task automatic test_store_stall();
    int pulses, first;
    do_reset();
    setin(7'b0100011, 3'b000, 7'd0, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (mode !== 3'd6) begin n_fail++; $display("FAIL sb_mode: got %0d want 6", mode); end
    tick();
    n_cmp++; if (extmode2_e !== 3'b010) begin n_fail++; $display("FAIL sb_e: ext2=%b want 010", extmode2_e); end
    for (int k = 0; k < 2; k++) begin
      setin(7'd0, 3'd0, 7'd0, 0, 1, 0, 0, 0);
      tick();
      n_cmp++; if (extmode2_e !== 3'b010 || mem_write_m !== 1'b0) begin n_fail++; $display("FAIL sb_hold: ext2=%b mw=%0b want 010/0", extmode2_e, mem_write_m); end
    end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    pulses = 0; first = -1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_write_m === 1'b1) begin pulses++; if (first < 0) first = k; end
    end
    n_cmp++; if (pulses != 1 || first != 0) begin n_fail++; $display("FAIL sb_pulse: pulses=%0d at=%0d want 1 at 0", pulses, first); end
  endtask

  task automatic test_flush();
    int m2r, rw, rw_at;
    do_reset();
    setin(7'b0110011, 3'b000, 7'd0, 1, 0, 0, 0, 0);
    tick();
    setin(7'b0000011, 3'b010, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (mem_read_e !== 1'b1) begin n_fail++; $display("FAIL flush_pre: mem_read_e=%0b want 1", mem_read_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 1, 0, 0);
    tick();
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    m2r = 0; rw = 0; rw_at = -1;
    for (int j = 0; j < M + 3; j++) begin
      if (j > 0) tick();
      if (mem_to_reg_m === 1'b1) m2r++;
      if (reg_write_w === 1'b1) begin rw++; rw_at = j; end
    end
    n_cmp++; if (m2r != 0) begin n_fail++; $display("FAIL flush_load: mem_to_reg_m seen %0d want 0", m2r); end
    n_cmp++; if (rw != 1 || rw_at != M - 1) begin n_fail++; $display("FAIL flush_older: rw_w count=%0d at=%0d want 1 at %0d", rw, rw_at, M - 1); end
  endtask

  task automatic test_ecall();
    do_reset();
    setin(7'b1110011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    for (int j = 1; j <= M + 1; j++) begin
      setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, (j == 1));
      tick();
      n_cmp++; if (stop !== 1'b0 || alu_src1_e !== 1'b0 || reg_write_w !== 1'b0) begin n_fail++; $display("FAIL ecall_drain: j=%0d stop=%0b src1=%0b rw_w=%0b want 0/0/0", j, stop, alu_src1_e, reg_write_w); end
    end
    setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (stop !== 1'b1) begin n_fail++; $display("FAIL ecall_stop: stop=%0b want 1", stop); end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++; if (stop !== 1'b1 || reg_write_w !== 1'b0 || dut_all !== model_all()) begin n_fail++; $display("FAIL ecall_halt: stop=%0b rw_w=%0b got %h want %h", stop, reg_write_w, dut_all, model_all()); end
    end
    setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, 1);
    tick();
    n_cmp++; if (stop !== 1'b0 || alu_src1_e !== 1'b0) begin n_fail++; $display("FAIL ecall_resume: stop=%0b src1=%0b want 0/0", stop, alu_src1_e); end
    setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (alu_src1_e !== 1'b1) begin n_fail++; $display("FAIL ecall_run: src1=%0b want 1", alu_src1_e); end
    // reset in the middle of a drain
    setin(7'b1110011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_cmp++; if (dut_all !== '0) begin n_fail++; $display("FAIL drain_reset: got %h want 0", dut_all); end
    setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (alu_src1_e !== 1'b1) begin n_fail++; $display("FAIL drain_reset_run: src1=%0b want 1", alu_src1_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    for (int j = 0; j < M + 3; j++) begin
      tick();
      n_cmp++; if (stop !== 1'b0) begin n_fail++; $display("FAIL drain_reset_stop: stop=%0b want 0", stop); end
    end
  endtask

  task automatic test_ecall_kill();
    do_reset();
    setin(7'b1110011, 3'd0, 7'd0, 1, 0, 1, 0, 0);
    tick();
    setin(7'b1110011, 3'd0, 7'd0, 1, 0, 0, 1, 0);
    tick();
    setin(7'b0010011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (alu_src1_e !== 1'b1) begin n_fail++; $display("FAIL kill_run: src1=%0b want 1", alu_src1_e); end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    for (int j = 0; j < M + 3; j++) begin
      tick();
      n_cmp++; if (stop !== 1'b0) begin n_fail++; $display("FAIL kill_stop: stop=%0b want 0", stop); end
    end
    // flush while draining does not cancel the halt
    setin(7'b1110011, 3'd0, 7'd0, 1, 0, 0, 0, 0);
    tick();
    for (int j = 0; j < M + 1; j++) begin
      setin(7'd0, 3'd0, 7'd0, 0, 0, 1, 0, 0);
      tick();
    end
    setin(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (stop !== 1'b1) begin n_fail++; $display("FAIL drain_flush: stop=%0b want 1", stop); end
  endtask

  task automatic test_muldiv();
    do_reset();
    setin(7'b0110011, 3'b000, 7'b0000001, 1, 0, 0, 0, 0);
    tick();
`ifdef CTRL_MULDIV_EN
    n_cmp++; if (muldiv_e !== 1'b1 || alu_op_e !== AW'(8)) begin n_fail++; $display("FAIL mul: muldiv=%0b op=%b want 1/1000", muldiv_e, alu_op_e); end
`else
    n_cmp++; if (muldiv_e !== 1'b0 || alu_op_e !== AW'(0)) begin n_fail++; $display("FAIL mul_plain: muldiv=%0b op=%b want 0/0000", muldiv_e, alu_op_e); end
`endif
    setin(7'b0110011, 3'b101, 7'b0000001, 1, 0, 0, 0, 0);
    tick();
    n_cmp++; if (dut_all !== model_all()) begin n_fail++; $display("FAIL divu: got %h want %h", dut_all, model_all()); end
  endtask

  task automatic test_random();
    logic [6:0] ops [0:9];
    logic [6:0] op;
    logic [6:0] f7;
    ops = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b1110011, 7'b1101111, 7'b0000000};
    do_reset();
    for (int c = 0; c < 800; c++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000001;
        1: f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      setin(op, 3'($urandom), f7, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0));
      rstn = ($urandom_range(0, 99) != 0);
      #1;
      n_cmp++; if (mode !== model_mode(opcode, funct3)) begin n_fail++; $display("FAIL rand_mode: c=%0d got %0d want %0d", c, mode, model_mode(opcode, funct3)); end
      tick();
      n_cmp++; if (dut_all !== model_all()) begin n_fail++; $display("FAIL rand_state: c=%0d got %h want %h", c, dut_all, model_all()); end
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bltu();
    test_load();
    test_store_stall();
    test_flush();
    test_ecall();
    test_ecall_kill();
    test_muldiv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
